// File: rtl/tour_pkg.sv
// Shared types and constants for the knight-tour command sequencer.
package tour_pkg;

  localparam int unsigned CMD_W     = 16;
  localparam int unsigned MOVE_W    = 8;
  localparam int unsigned IDX_W     = 5;
  localparam int unsigned NUM_MOVES = 24;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VERT   = 3'd1,
    WAIT_V = 3'd2,
    HORZ   = 3'd3,
    WAIT_H = 3'd4
  } state_t;

  localparam logic [3:0] OP_CAL     = 4'h2;
  localparam logic [3:0] OP_MOVE    = 4'h4;
  localparam logic [3:0] OP_FANFARE = 4'h5;
  localparam logic [3:0] OP_TOUR    = 4'h6;

  localparam logic [7:0] HDG_NORTH = 8'h00;
  localparam logic [7:0] HDG_WEST  = 8'h3F;
  localparam logic [7:0] HDG_SOUTH = 8'h7F;
  localparam logic [7:0] HDG_EAST  = 8'hBF;

  // A5 acknowledges idle/completion, 5A reports a tour leg in progress.
  localparam logic [7:0] RESP_DONE = 8'hA5;
  localparam logic [7:0] RESP_TOUR = 8'h5A;

  typedef struct packed {
    logic [3:0] opcode;
    logic [7:0] heading;
    logic [3:0] squares;
  } cmd_t;

  function automatic cmd_t mk_cmd(input logic [3:0] op, input logic [7:0] hdg,
                                  input logic [2:0] cnt);
    cmd_t c;
    c.opcode  = op;
    c.heading = hdg;
    c.squares = {1'b0, cnt};
    return c;
  endfunction

endpackage

// File: rtl/move_decode.sv
// Turns a one-hot knight move into its vertical and horizontal leg commands.
module move_decode
  import tour_pkg::*;
(
  input  logic [MOVE_W-1:0] move,
  output logic [CMD_W-1:0]  vert_cmd,
  output logic [CMD_W-1:0]  horz_cmd,
  output logic              illegal
);

  logic [2:0] idx;

  // Lowest set bit wins for a non-one-hot move.
  always_comb begin
    idx = 3'd0;
    for (int i = MOVE_W - 1; i >= 0; i--) begin
      if (move[i]) idx = 3'(i);
    end
  end

  // Bits 0-3 are two-up/one-over, bits 4-7 one-up/two-over; idx[1] picks south, idx[0] west.
  always_comb begin
    vert_cmd = mk_cmd(OP_MOVE, idx[1] ? HDG_SOUTH : HDG_NORTH, idx[2] ? 3'd1 : 3'd2);
    horz_cmd = mk_cmd(OP_FANFARE, idx[0] ? HDG_WEST : HDG_EAST, idx[2] ? 3'd2 : 3'd1);
    illegal  = (move == '0);
  end

endmodule

// File: rtl/tour_cmd.sv
// Command mux between the UART path and the knight-tour sequencer that replays
// each move as a vertical then a horizontal leg.
module tour_cmd
  import tour_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start_tour,
  input  logic [MOVE_W-1:0] move,
  output logic [IDX_W-1:0]  mv_indx,
  input  logic [CMD_W-1:0]  cmd_UART,
  input  logic              cmd_rdy_UART,
  input  logic              clr_cmd_rdy,
  input  logic              send_resp,
  output logic [CMD_W-1:0]  cmd,
  output logic              cmd_rdy,
  output logic              clr_cmd_rdy_UART,
  output logic [7:0]        resp
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MOVES - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] mv_indx_q, mv_indx_d;
  logic [CMD_W-1:0] vert_cmd, horz_cmd;
  logic             illegal;

  move_decode u_move_decode (
    .move     (move),
    .vert_cmd (vert_cmd),
    .horz_cmd (horz_cmd),
    .illegal  (illegal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mv_indx_q <= '0;
    end else begin
      state_q   <= state_d;
      mv_indx_q <= mv_indx_d;
    end
  end

  // Next state plus the combinational command/response mux.
  always_comb begin
    state_d          = state_q;
    mv_indx_d        = mv_indx_q;
    cmd              = vert_cmd;
    cmd_rdy          = 1'b0;
    clr_cmd_rdy_UART = 1'b0;
    resp             = RESP_TOUR;

    unique case (state_q)
      IDLE: begin
        cmd              = cmd_UART;
        cmd_rdy          = cmd_rdy_UART;
        clr_cmd_rdy_UART = clr_cmd_rdy;
        resp             = RESP_DONE;
        if (start_tour) begin
          state_d   = VERT;
          mv_indx_d = '0;
        end
      end
      VERT: begin
        if (illegal) begin
          state_d   = IDLE;
          mv_indx_d = '0;
        end else begin
          cmd_rdy = 1'b1;
          if (clr_cmd_rdy) state_d = WAIT_V;
        end
      end
      WAIT_V: begin
        if (send_resp) state_d = HORZ;
      end
      HORZ: begin
        cmd     = horz_cmd;
        cmd_rdy = 1'b1;
        if (clr_cmd_rdy) state_d = WAIT_H;
      end
      WAIT_H: begin
        cmd = horz_cmd;
        // The final leg answers with the completion code so the host sees the tour end.
        if (mv_indx_q == LAST_IDX) begin
          resp = RESP_DONE;
          if (send_resp) state_d = IDLE;
        end else if (send_resp) begin
          mv_indx_d = mv_indx_q + IDX_W'(1);
          state_d   = VERT;
        end
      end
      default: begin
        state_d   = IDLE;
        mv_indx_d = '0;
      end
    endcase
  end

  assign mv_indx = mv_indx_q;

endmodule
